conv3x3_window_gen: RTL and testbench
=====================================

# conv3x3_window_gen

Streaming 3x3 sliding-window generator that sits directly upstream of the nine-tap pipelined MAC. It accepts one raster-order pixel per valid cycle, buffers the two previous image rows, and presents the nine pixels of each complete 3x3 window in parallel, one window per accepted pixel once the window is full. Its outputs drive the MAC's `a0..a8` and `input_valid`. The convolution is "valid" only: there is no padding, and a frame yields `(IMG_WIDTH-2)*(IMG_HEIGHT-2)` windows.

## Interface
Parameters:
- `DATA_WIDTH`, 16: pixel width, signed.
- `IMG_WIDTH`, 32: pixels per row; must be ≥ 3.
- `IMG_HEIGHT`, 32: rows per frame; must be ≥ 3.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `arst_in`  in  1  reset, asynchronous, active-high.
- `clear_in`  in  1  synchronous frame restart; takes priority over `pix_valid`.
- `pix_valid`  in  1  `pix_in` carries the next raster pixel this cycle.
- `pix_in`  in  `DATA_WIDTH`  pixel value, signed.
- `w0`..`w8`  out  `DATA_WIDTH` each  window taps, row-major.
  - `w0..w2` are the oldest row, `w6..w8` the newest row.
  - `w8` is the most recently accepted pixel.
- `window_valid`  out  1  the window taps hold a complete window; drives the MAC `input_valid`.
- `frame_done`  out  1  one-cycle pulse, coincident with the last window of the frame.

The block has no backpressure. The downstream MAC is always ready.

## Operation
- **Counters.** Column counter `col` runs 0..IMG_WIDTH-1 and row counter `row` runs 0..IMG_HEIGHT-1. Both advance only on `pix_valid`.
  - `col` wraps to 0 at IMG_WIDTH-1 and increments `row`.
  - `row` wraps to 0 after the last pixel of the frame, so back-to-back frames need no idle cycles.
- **Line buffers.** Two cascaded one-row delays, each of depth IMG_WIDTH, written and read only on `pix_valid`.
  - `lb0_out` is the pixel one row above the current pixel; `lb1_out` is the pixel two rows above.
- **Window registers.** A 3x3 register array. On `pix_valid`, each row shifts left by one column and loads its new right column:
  - top row loads `lb1_out` into `w2`;
  - middle row loads `lb0_out` into `w5`;
  - bottom row loads `pix_in` into `w8`.
- **Window valid.** A window is complete when the accepted pixel has `row ≥ 2` and `col ≥ 2`.
  - `window_valid` is registered: it is 1 in the cycle after such a pixel is accepted, and 0 after any other cycle, including cycles with `pix_valid` = 0.
- **Frame done.** `frame_done` is 1 in the cycle after the pixel at (`IMG_HEIGHT-1`, `IMG_WIDTH-1`) is accepted, together with `window_valid` = 1.
- **Row-boundary garbage.** Windows that straddle a row boundary (`col` < 2) are produced internally but never flagged valid.
- **Clear.** When `clear_in` = 1, `col`, `row`, `window_valid` and `frame_done` go to 0 next cycle.
  - Any `pix_valid` in the same cycle is dropped.
  - Line-buffer and window contents are left stale. Gating on `row`/`col` makes stale data unobservable.
- **Reset.** `arst_in` forces `col`, `row`, `window_valid`, `frame_done` and `w0..w8` to 0 immediately.
  - Line-buffer storage is not reset.
  - Reset mid-frame aborts the frame; the next accepted pixel is (0,0).

## Timing
- Latency: 1 cycle from acceptance of the completing pixel to `window_valid`/taps.
- Throughput: 1 window per cycle with continuous `pix_valid`.
- Gaps in `pix_valid` hold all state; taps stay stable, `window_valid` = 0.
- Line-buffer read and write share the same `pix_valid` cycle: read-before-write at the same address.
  - Implementation is a register array, or a single-port RAM with a 1-cycle read, pre-addressed by `col`.
- First valid window of a frame: after accepted pixel number `2*IMG_WIDTH+2` (0-based).

## Structure
- Shared package `conv_pkg`:
  - `pixel_t` (signed `DATA_WIDTH`);
  - window index constants `W_TOP_L`…`W_BOT_R` (0..8);
  - helper function `clog2_min1` for counter widths.
- One sub-module, `line_buffer`:
  - a parameterised DEPTH×WIDTH one-row delay with `we`;
  - instantiated twice and cascaded;
  - uses an internal circular pointer, so it needs no reset on storage.
- The top level holds the counters, window registers and flag logic.

## Test plan
All scenarios use `IMG_WIDTH`=4, `IMG_HEIGHT`=4.
- **Basic frame.** Pixels 0..15 continuous.
  - Exactly 4 `window_valid` pulses.
  - 1st: 0,1,2,4,5,6,8,9,10.
  - 2nd: 1,2,3,5,6,7,9,10,11.
  - 3rd: 4,5,6,8,9,10,12,13,14.
  - 4th: 5,6,7,9,10,11,13,14,15, with `frame_done`=1.
- **Gapped input.** Same frame with `pix_valid` toggling 1,0,1,0.
  - Identical window sequence.
  - `window_valid` never 1 for two consecutive cycles.
  - Taps are stable during gaps.
- **Back-to-back frames.** Two frames with values 0..15 then 100..115, continuous.
  - Second-frame first window: 100,101,102,104,105,106,108,109,110.
  - No window mixes values from both frames.
- **Clear mid-frame.** Send pixels 0..9, assert `clear_in` together with a `pix_valid` carrying 99, then send a full frame 0..15.
  - 99 is dropped.
  - Output is exactly the four windows of the basic-frame scenario.
- **Reset mid-frame.** Assert `arst_in` asynchronously after pixel 6.
  - All outputs 0 within the same cycle.
  - A subsequent full frame yields the basic-frame result.
- **Random check.** Random signed pixels, including -32768 and 32767, over 3 frames.
  - Taps match a reference model bit-exactly.
  - `window_valid` count is 4 per frame.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution front end.
// Window taps are indexed row-major, top-left = 0 through bottom-right = 8.
package conv_pkg;

  localparam int unsigned PIXEL_W = 16;

  typedef logic signed [PIXEL_W-1:0] pixel_t;

  localparam int unsigned W_TOP_L = 0;
  localparam int unsigned W_TOP_M = 1;
  localparam int unsigned W_TOP_R = 2;
  localparam int unsigned W_MID_L = 3;
  localparam int unsigned W_MID_M = 4;
  localparam int unsigned W_MID_R = 5;
  localparam int unsigned W_BOT_L = 6;
  localparam int unsigned W_BOT_M = 7;
  localparam int unsigned W_BOT_R = 8;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One-row delay line: dout is the sample written DEPTH accepted writes ago.
// Read-before-write at a circular pointer; only the pointer is reset.
module line_buffer
  import conv_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned PW = clog2_min1(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (we) ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[ptr_q] <= din;
  end

  assign dout = mem_q[ptr_q];

endmodule

// File: rtl/conv3x3_window_gen.sv
// Streaming 3x3 sliding-window generator ("valid" convolution, no padding).
// Two cascaded row delays feed a 3x3 shift array; raster counters gate validity.
module conv3x3_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IMG_WIDTH  = 32,
  parameter int unsigned IMG_HEIGHT = 32
) (
  input  logic                         clk,
  input  logic                         arst_in,
  input  logic                         clear_in,
  input  logic                         pix_valid,
  input  logic signed [DATA_WIDTH-1:0] pix_in,
  output logic signed [DATA_WIDTH-1:0] w0,
  output logic signed [DATA_WIDTH-1:0] w1,
  output logic signed [DATA_WIDTH-1:0] w2,
  output logic signed [DATA_WIDTH-1:0] w3,
  output logic signed [DATA_WIDTH-1:0] w4,
  output logic signed [DATA_WIDTH-1:0] w5,
  output logic signed [DATA_WIDTH-1:0] w6,
  output logic signed [DATA_WIDTH-1:0] w7,
  output logic signed [DATA_WIDTH-1:0] w8,
  output logic                         window_valid,
  output logic                         frame_done
);

  localparam int unsigned CW = clog2_min1(IMG_WIDTH);
  localparam int unsigned RW = clog2_min1(IMG_HEIGHT);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic signed [DATA_WIDTH-1:0] win_q [9];
  logic signed [DATA_WIDTH-1:0] win_d [9];

  logic                  accept;
  logic [DATA_WIDTH-1:0] lb0_out, lb1_out;

  // A pixel offered together with clear is dropped, so it must not enter the line buffers.
  assign accept = pix_valid & ~clear_in;

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_lb0 (
    .clk  (clk),
    .rst  (arst_in),
    .we   (accept),
    .din  (pix_in),
    .dout (lb0_out)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_lb1 (
    .clk  (clk),
    .rst  (arst_in),
    .we   (accept),
    .din  (lb0_out),
    .dout (lb1_out)
  );

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    win_d   = win_q;
    if (clear_in) begin
      col_d = '0;
      row_d = '0;
    end else if (pix_valid) begin
      win_d[W_TOP_L] = win_q[W_TOP_M];
      win_d[W_TOP_M] = win_q[W_TOP_R];
      win_d[W_TOP_R] = $signed(lb1_out);
      win_d[W_MID_L] = win_q[W_MID_M];
      win_d[W_MID_M] = win_q[W_MID_R];
      win_d[W_MID_R] = $signed(lb0_out);
      win_d[W_BOT_L] = win_q[W_BOT_M];
      win_d[W_BOT_M] = win_q[W_BOT_R];
      win_d[W_BOT_R] = pix_in;
      valid_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
      done_d  = (row_q == RW'(IMG_HEIGHT - 1)) && (col_q == CW'(IMG_WIDTH - 1));
      if (col_q == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  assign w0           = win_q[W_TOP_L];
  assign w1           = win_q[W_TOP_M];
  assign w2           = win_q[W_TOP_R];
  assign w3           = win_q[W_MID_L];
  assign w4           = win_q[W_MID_M];
  assign w5           = win_q[W_MID_R];
  assign w6           = win_q[W_BOT_L];
  assign w7           = win_q[W_BOT_M];
  assign w8           = win_q[W_BOT_R];
  assign window_valid = valid_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Directed bench for conv3x3_window_gen on a 4x4 image, checked against a
// 2-D image reference model plus hand-computed window tables.
module tb_conv3x3_window_gen;
  import conv_pkg::*;

  localparam int unsigned W = 4;
  localparam int unsigned H = 4;

  logic   clk = 1'b0;
  logic   arst_in = 1'b0;
  logic   clear_in = 1'b0;
  logic   pix_valid = 1'b0;
  pixel_t pix_in = '0;
  pixel_t w0, w1, w2, w3, w4, w5, w6, w7, w8;
  logic   window_valid, frame_done;

  conv3x3_window_gen #(.DATA_WIDTH(16), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk          (clk),
    .arst_in      (arst_in),
    .clear_in     (clear_in),
    .pix_valid    (pix_valid),
    .pix_in       (pix_in),
    .w0           (w0),
    .w1           (w1),
    .w2           (w2),
    .w3           (w3),
    .w4           (w4),
    .w5           (w5),
    .w6           (w6),
    .w7           (w7),
    .w8           (w8),
    .window_valid (window_valid),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  pixel_t obs [9];
  assign obs = '{w0, w1, w2, w3, w4, w5, w6, w7, w8};

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  pixel_t img [H][W];
  int     m_col, m_row;
  logic   exp_vld, exp_done, taps_known;
  pixel_t exp_taps [9];

  // Hand-computed basic-frame windows (pixel value = row*4+col)
  int tbl [4][9] = '{
    '{0, 1, 2, 4, 5, 6, 8, 9, 10},
    '{1, 2, 3, 5, 6, 7, 9, 10, 11},
    '{4, 5, 6, 8, 9, 10, 12, 13, 14},
    '{5, 6, 7, 9, 10, 11, 13, 14, 15}
  };
  logic use_tbl;
  int   tbl_off, tbl_idx, win_seen;

  task automatic chk(input string tag, input int o, input int e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_row = 0;
    exp_vld = 1'b0; exp_done = 1'b0; taps_known = 1'b1;
    for (int i = 0; i < 9; i++) exp_taps[i] = '0;
  endtask

  task automatic step(input logic v, input int pix, input logic clr);
    pixel_t p;
    p = pixel_t'(pix);
    pix_valid = v; pix_in = p; clear_in = clr;
    @(posedge clk); #1;
    pix_valid = 1'b0; clear_in = 1'b0;
    exp_vld = 1'b0; exp_done = 1'b0;
    if (clr) begin
      m_col = 0; m_row = 0;
    end else if (v) begin
      img[m_row][m_col] = p;
      exp_vld  = (m_row >= 2) && (m_col >= 2);
      exp_done = (m_row == H - 1) && (m_col == W - 1);
      taps_known = exp_vld;
      if (exp_vld)
        for (int i = 0; i < 9; i++) exp_taps[i] = img[m_row - 2 + i / 3][m_col - 2 + i % 3];
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else m_col++;
    end
    chk("window_valid", int'(window_valid), int'(exp_vld));
    chk("frame_done", int'(frame_done), int'(exp_done));
    if (taps_known)
      for (int i = 0; i < 9; i++) chk($sformatf("tap%0d", i), int'(obs[i]), int'(exp_taps[i]));
    if (window_valid) win_seen++;
    if (use_tbl && exp_vld) begin
      if (tbl_idx < 4)
        for (int i = 0; i < 9; i++)
          chk($sformatf("tbl_win%0d_tap%0d", tbl_idx, i), int'(obs[i]), tbl[tbl_idx][i] + tbl_off);
      tbl_idx++;
    end
  endtask

  task automatic frame(input int base, input logic gapped);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, base + k, 1'b0);
      if (gapped) step(1'b0, 12345, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    use_tbl = 1'b0; tbl_off = 0; tbl_idx = 0; win_seen = 0;
    arst_in = 1'b1;
    #12;
    chk("rst_window_valid", int'(window_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    for (int i = 0; i < 9; i++) chk($sformatf("rst_tap%0d", i), int'(obs[i]), 0);
    arst_in = 1'b0;
    @(negedge clk);

    // Basic frame
    use_tbl = 1'b1; tbl_idx = 0; win_seen = 0;
    frame(0, 1'b0);
    chk("basic_win_count", win_seen, 4);
    chk("basic_tbl_count", tbl_idx, 4);

    // Gapped input
    tbl_idx = 0; win_seen = 0;
    frame(0, 1'b1);
    chk("gapped_win_count", win_seen, 4);

    // Back-to-back frames; second frame table offset by 100
    use_tbl = 1'b0;
    frame(0, 1'b0);
    use_tbl = 1'b1; tbl_off = 100; tbl_idx = 0;
    frame(100, 1'b0);
    chk("b2b_tbl_count", tbl_idx, 4);
    tbl_off = 0;

    // Clear mid-frame with a dropped pixel
    use_tbl = 1'b0;
    for (int k = 0; k < 10; k++) step(1'b1, k, 1'b0);
    step(1'b1, 99, 1'b1);
    use_tbl = 1'b1; tbl_idx = 0; win_seen = 0;
    frame(0, 1'b0);
    chk("clear_win_count", win_seen, 4);

    // Asynchronous reset after pixel 6
    use_tbl = 1'b0;
    for (int k = 0; k <= 6; k++) step(1'b1, k, 1'b0);
    #2 arst_in = 1'b1;
    #1;
    chk("arst_window_valid", int'(window_valid), 0);
    chk("arst_frame_done", int'(frame_done), 0);
    for (int i = 0; i < 9; i++) chk($sformatf("arst_tap%0d", i), int'(obs[i]), 0);
    model_reset();
    @(negedge clk);
    arst_in = 1'b0;
    use_tbl = 1'b1; tbl_idx = 0; win_seen = 0;
    frame(0, 1'b0);
    chk("arst_win_count", win_seen, 4);

    // Random frames with extreme values
    use_tbl = 1'b0;
    for (int f = 0; f < 3; f++) begin
      win_seen = 0;
      for (int k = 0; k < 16; k++) begin
        int v;
        v = int'($urandom_range(0, 65535)) - 32768;
        if (k == 0 || k == 10) v = -32768;
        if (k == 5 || k == 15) v = 32767;
        step(1'b1, v, 1'b0);
      end
      chk($sformatf("rand_f%0d_win_count", f), win_seen, 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
